// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART for one bus hub slot: TX/RX FIFOs, programmable
// baud divisor and sticky error flags.
//
// Bus handshake (valid/ready): a request is (wen|ren) & active while ready was
// low in the previous cycle. All side effects happen on the accepting edge,
// ready pulses high for exactly the next cycle with rdata valid in that cycle,
// and the hub is expected to keep the request asserted until it sees ready.
// If wen and ren are both high the request is treated as a write.
module uart_peripheral #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // Bus decode
  logic        req, wr_req, rd_req;
  logic [1:0]  sel;
  logic [31:0] rd_val;
  logic [15:0] div, div_m, div_new;
  logic        tx_overflow, rx_overrun, frame_err;
  logic        tx_full, tx_busy, rx_nonempty;
  logic        cpu_tx_push, cpu_rx_pop, status_wr;

  // FIFOs
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_push_ok, rx_push_ok;

  // TX engine
  uart_state_t tx_state, tx_next;
  logic [15:0] tx_cnt, tx_frame_div;
  logic [7:0]  tx_shreg;
  logic [2:0]  tx_bit;
  logic        tx_pop, tx_bit_end;

  // RX engine
  uart_state_t rx_state, rx_next;
  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev, rx_fall;
  logic [15:0] rx_cnt, rx_frame_div;
  logic [7:0]  rx_shreg;
  logic [2:0]  rx_bit;
  logic        rx_push, rx_ferr_set, rx_half_end, rx_bit_end;

  logic unused_bits;
  assign unused_bits = ^{wdata[31:16], wmask[3:2], addr[1:0]};

  assign active = (addr[31:4] == BASE_ADDR[31:4]);
  assign req    = (wen | ren) & active & ~ready;
  assign wr_req = req & wen;
  assign rd_req = req & ~wen;
  assign sel    = addr[3:2];

  assign tx_full     = (tx_count == FULL);
  assign rx_nonempty = (rx_count != '0);
  assign tx_busy     = (tx_state != S_IDLE) | (tx_count != '0);

  assign cpu_tx_push = wr_req & (sel == 2'd0) & wmask[0];
  assign status_wr   = wr_req & (sel == 2'd1) & wmask[0];
  assign tx_push_ok  = cpu_tx_push & (~tx_full | tx_pop);
  assign rx_push_ok  = rx_push & ((rx_count != FULL) | cpu_rx_pop);

  // Byte-masked divisor update, clamped so a bit is never shorter than 4 cycles
  assign div_m   = {wmask[1] ? wdata[15:8] : div[15:8], wmask[0] ? wdata[7:0] : div[7:0]};
  assign div_new = (div_m < 16'd4) ? 16'd4 : div_m;

  // Read mux; a DATA read pops only when the RX FIFO holds a byte
  always_comb begin
    rd_val     = '0;
    cpu_rx_pop = 1'b0;
    if (rd_req) begin
      case (sel)
        2'd0: if (rx_nonempty) begin
          rd_val     = {1'b1, 23'b0, rx_mem[rx_rd]};
          cpu_rx_pop = 1'b1;
        end
        2'd1:    rd_val = {26'b0, frame_err, rx_overrun, tx_overflow, tx_busy, rx_nonempty, tx_full};
        2'd2:    rd_val = {16'b0, div};
        default: rd_val = '0;
      endcase
    end
  end

  // Response register: one-cycle ready pulse with the captured read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= req;
      rdata <= rd_val;
    end
  end

  // Baud divisor register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= DEFAULT_DIV;
    else if (wr_req && sel == 2'd2) div <= div_new;
  end

  // Sticky flags: write-1-to-clear, a same-cycle set takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (status_wr && wdata[3]) tx_overflow <= 1'b0;
      if (status_wr && wdata[4]) rx_overrun  <= 1'b0;
      if (status_wr && wdata[5]) frame_err   <= 1'b0;
      if (cpu_tx_push && !tx_push_ok) tx_overflow <= 1'b1;
      if (rx_push && !rx_push_ok)     rx_overrun  <= 1'b1;
      if (rx_ferr_set)                frame_err   <= 1'b1;
    end
  end

  // FIFO storage (contents need no reset; the counts define validity)
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr] <= wdata[7:0];
    if (rx_push_ok) rx_mem[rx_wr] <= rx_shreg;
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
      rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
    end else begin
      if (tx_push_ok) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)     tx_rd <= tx_rd + PW'(1);
      case ({tx_push_ok, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
      if (rx_push_ok) rx_wr <= rx_wr + PW'(1);
      if (cpu_rx_pop) rx_rd <= rx_rd + PW'(1);
      case ({rx_push_ok, cpu_rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  assign tx_bit_end = (tx_cnt == tx_frame_div - 16'd1);

  // TX next state; STOP chains straight into START when more bytes wait
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      S_IDLE: if (tx_count != '0) begin
        tx_pop  = 1'b1;
        tx_next = S_START;
      end
      S_START: if (tx_bit_end) tx_next = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = S_STOP;
      S_STOP: if (tx_bit_end) begin
        if (tx_count != '0) begin
          tx_pop  = 1'b1;
          tx_next = S_START;
        end else begin
          tx_next = S_IDLE;
        end
      end
      default: tx_next = S_IDLE;
    endcase
  end

  // TX datapath: divisor is latched per frame so DIV writes affect the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt       <= '0;
      tx_frame_div <= DEFAULT_DIV;
      tx_shreg     <= '0;
      tx_bit       <= '0;
    end else if (tx_pop) begin
      tx_cnt       <= '0;
      tx_frame_div <= div;
      tx_shreg     <= tx_mem[tx_rd];
      tx_bit       <= '0;
    end else if (tx_state != S_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt <= '0;
        if (tx_state == S_DATA) begin
          tx_shreg <= {1'b0, tx_shreg[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // Line is driven from state so reset returns it high without waiting for a clock
  assign uart_tx = (tx_state == S_START) ? 1'b0 :
                   (tx_state == S_DATA)  ? tx_shreg[0] : 1'b1;

  // RX synchroniser and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s        = rx_sync[1];
  assign rx_fall     = rx_prev & ~rx_s;
  assign rx_half_end = (rx_cnt == (rx_frame_div >> 1) - 16'd1);
  assign rx_bit_end  = (rx_cnt == rx_frame_div - 16'd1);

  // RX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next state; a start bit that is high at its midpoint is a glitch
  always_comb begin
    rx_next     = rx_state;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_half_end) rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP: if (rx_bit_end) begin
        rx_next     = S_IDLE;
        rx_push     = rx_s;
        rx_ferr_set = ~rx_s;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  // RX datapath: counters realigned to bit centres after the half-bit start wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt       <= '0;
      rx_frame_div <= DEFAULT_DIV;
      rx_shreg     <= '0;
      rx_bit       <= '0;
    end else begin
      case (rx_state)
        S_IDLE: if (rx_fall) begin
          rx_cnt       <= '0;
          rx_frame_div <= div;
          rx_bit       <= '0;
        end
        S_START: rx_cnt <= rx_half_end ? 16'd0 : rx_cnt + 16'd1;
        default: begin
          if (rx_bit_end) begin
            rx_cnt <= '0;
            if (rx_state == S_DATA) begin
              rx_shreg <= {rx_s, rx_shreg[7:1]};
              rx_bit   <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
